// File: rtl/angle_rom_fetch_ctrl.sv
// Fetch sequencer for the angle-detail ROM: walks a wrapping address range and streams bytes through a FWFT FIFO.
// Optional `ANGLE_FETCH_CHECKSUM_EN adds a running XOR checksum output of the handshaked bytes.
module angle_rom_fetch_ctrl #(
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = 22,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int LW = $clog2(MEM_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [LW-1:0]        length,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rom_enable,
  output logic [AW-1:0]        rom_address,
  input  logic [MEM_WIDTH-1:0] rom_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MEM_WIDTH-1:0] out_data,
`ifdef ANGLE_FETCH_CHECKSUM_EN
  output logic [MEM_WIDTH-1:0] checksum,
`endif
  output logic [AW-1:0]        out_index
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state_q;
  logic                  busy_q, done_q, err_q;
  logic                  en_q;
  logic [AW-1:0]         rom_address_q;
  logic                  infl_q;
  logic [AW-1:0]         infl_addr_q;
  logic [AW-1:0]         addr_q;
  logic [LW-1:0]         remain_q;
  logic [MEM_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic [AW-1:0]         idx_mem  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic                  pop;
  logic [CW-1:0]         cnt_after;
  logic                  credit_ok;
  logic [LW-1:0]         len_clamp;
  logic                  addr_bad;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Issue decisions are registered, so the credit check looks one cycle ahead:
  // occupancy after this edge plus the read on the ROM bus right now.
  always_comb begin
    pop       = (count_q != '0) && out_ready;
    cnt_after = count_q + CW'(infl_q) - CW'(pop);
    credit_ok = (cnt_after + CW'(en_q)) < CW'(FIFO_DEPTH);
    len_clamp = (int'(length) > MEM_DEPTH) ? LW'(MEM_DEPTH) : length;
    addr_bad  = int'(start_addr) >= MEM_DEPTH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      en_q          <= 1'b0;
      rom_address_q <= '0;
      infl_q        <= 1'b0;
      infl_addr_q   <= '0;
      addr_q        <= '0;
      remain_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        idx_mem[i]  <= '0;
      end
    end else begin
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      infl_q  <= en_q;
      count_q <= cnt_after;
      if (en_q) infl_addr_q <= rom_address_q;
      if (infl_q) begin
        data_mem[wr_ptr_q] <= rom_dout;
        idx_mem[wr_ptr_q]  <= infl_addr_q;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            err_q    <= addr_bad;
            addr_q   <= start_addr;
            remain_q <= len_clamp;
            if (addr_bad || len_clamp == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              // First read goes out in the cycle right after acceptance.
              en_q          <= 1'b1;
              rom_address_q <= start_addr;
              addr_q        <= wrap_inc(start_addr);
              remain_q      <= len_clamp - 1'b1;
              busy_q        <= 1'b1;
              state_q       <= (len_clamp == LW'(1)) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (credit_ok) begin
            en_q          <= 1'b1;
            rom_address_q <= addr_q;
            addr_q        <= wrap_inc(addr_q);
            remain_q      <= remain_q - 1'b1;
            if (remain_q == LW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!en_q && cnt_after == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ANGLE_FETCH_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] csum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ data_mem[rd_ptr_q];
    end
  end

  assign checksum = csum_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rom_enable  = en_q;
  assign rom_address = rom_address_q;
  assign out_valid   = (count_q != '0);
  assign out_data    = data_mem[rd_ptr_q];
  assign out_index   = idx_mem[rd_ptr_q];

endmodule

// File: doc/angle_rom_fetch_ctrl.md
# angle_rom_fetch_ctrl

Read sequencer and stream adapter that sits directly upstream/downstream of the angle-detail ROM (`rams_sp_rom_angle_comb_detail`-style single-port ROM with 1-cycle registered read). On a start command it walks a contiguous, wrapping address range, drives the ROM `enable`/`address`, absorbs the ROM read latency, and presents each byte on a valid/ready stream with full backpressure via a small internal FIFO.

## Interface
- `MEM_WIDTH`, 8: ROM data width.
- `MEM_DEPTH`, 22: ROM entries. AW = $clog2(MEM_DEPTH), LW = $clog2(MEM_DEPTH+1).
- `FIFO_DEPTH`, 4: output buffer entries (power of two, ≥2).
- Clock is `clock`; reset is `reset`, synchronous, active-high.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous active-high reset.
- `start` in 1: begin a fetch run; sampled only in IDLE.
- `start_addr` in AW: first ROM address.
- `length` in LW: entries to fetch, 0..MEM_DEPTH.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `err` out 1: sticky until next accepted `start`; set when `start_addr` ≥ MEM_DEPTH.
- `rom_enable` out 1: ROM read strobe.
- `rom_address` out AW: ROM read address.
- `rom_dout` in MEM_WIDTH: ROM data, valid the cycle after `rom_enable`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out MEM_WIDTH, `out_index` out AW: output stream; `out_index` is the ROM address the byte came from.

## Operation
- States: IDLE → FETCH → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches `start_addr`, `length` into `addr_q`, `remain_q`; clears `err`. `length`=0 → DONE directly (no ROM reads, no beats). `start_addr` ≥ MEM_DEPTH → set `err`, go DONE, no reads. `length` > MEM_DEPTH clamped to MEM_DEPTH.
- FETCH: issue read (`rom_enable`=1, `rom_address`=`addr_q`) when fifo_count + inflight < FIFO_DEPTH. Per issue: `remain_q`−1; `addr_q` +1, wrapping MEM_DEPTH−1 → 0. `remain_q`=0 after issue → DRAIN.
- Inflight flag: set on issue, write `rom_dout` + its address into FIFO next cycle. At most one read in flight per cycle; pipelined issue every cycle allowed when space permits.
- DRAIN: no issues; wait until inflight=0 and FIFO empty → DONE.
- DONE: `done`=1 one cycle, `busy`=0 → IDLE.
- `busy`=1 in FETCH and DRAIN only. `start` outside IDLE ignored.
- FIFO: first-word-fall-through from registered storage; simultaneous write and read when full-minus-inflight allowed; never overflows (credit check above).
- `rom_enable`=0 whenever no issue; `rom_address` holds last value.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rom_enable`=0, `rom_address`=0, `out_valid`=0, `out_data`=0, `out_index`=0; FIFO empty, inflight=0, state IDLE.
- `start` accepted cycle T → first `rom_enable` cycle T+1 → `rom_dout` valid T+2, written at end of T+2 → `out_valid`=1 in T+3.
- With `out_ready` held 1: one beat per cycle, T+3 … T+2+N. `done` pulses in the cycle after the final handshake.
- `out_data`/`out_index` stable while `out_valid`=1 and `out_ready`=0.
- `reset` mid-run: next cycle all state as reset; inflight ROM data discarded; no `done`.
- Error/zero-length: `done` at T+1, `err` visible from T+1.

## Configuration
- `ANGLE_FETCH_CHECKSUM_EN` defined: adds output `checksum` (MEM_WIDTH), XOR of all bytes handshaked in the current run, cleared on accepted `start`, held after `done`; reset 0.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan
- start_addr=0, length=3, `out_ready`=1 → beats 0x00/idx0, 0x02/idx1, 0x45/idx2 at T+3..T+5; `done` at T+6; `busy` T+1..T+5.
- start_addr=20, length=4 → `out_index` 20,21,0,1 (wrap); data matches ROM entries.
- length=22, `out_ready` toggling 1-of-3 → 22 beats in address order, no drop/dup, `rom_enable` stalls when FIFO+inflight=4, data held under stall.
- length=0 → `done` at T+1, no `rom_enable`, no beats; start_addr=25 → `err`=1, `done` at T+1.
- `reset` asserted mid-FETCH with 2 entries buffered → next cycle `out_valid`=0, `busy`=0; new start proceeds normally.
- With `ANGLE_FETCH_CHECKSUM_EN`: run 0..2 → `checksum`=0x47.
